game_state_ctrl: RTL and testbench
==================================

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded at new game (1..3).
REQ-002 Parameter GOLD_TARGET, default 8, gold pickups needed to win (1..15).
REQ-003 Parameter INV_FRAMES, default 60, post-hit invulnerability length in frames (1..255).
REQ-004 Parameter SCREEN_FRAMES, default 180, auto-return delay in frames (1..1023); used only under AUTO_RETURN_EN.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 resetN  in  1  asynchronous active-low reset.
REQ-007 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-008 start_key  in  1  level, synchronous to clk, 1 = pressed.
REQ-009 player_hit  in  1  one-cycle pulse, player touched alien.
REQ-010 gold_collected  in  1  one-cycle pulse, one gold bag taken.
REQ-011 game_state  out  3  1 = START, 2 = PLAY, 3 = WIN, 4 = GAME_OVER; feeds the drawing mux.
REQ-012 lives  out  2  remaining lives.
REQ-013 gold_count  out  4  gold collected this game.
REQ-014 new_game  out  1  one-cycle pulse; other blocks reinitialise on it.
REQ-015 respawn  out  1  one-cycle pulse after a non-fatal hit.
REQ-016 invuln  out  1  high while hits are ignored.

Function
REQ-017 All outputs registered; an input event in cycle n is reflected on the outputs in cycle n+1.
REQ-018 Key press = start_key high while previous-cycle start_key low; the previous-cycle register resets to 1, so a key held through reset is not a press.
REQ-019 START: key press -> PLAY; same edge: lives = LIVES_INIT, gold_count = 0, invuln = 0, new_game = 1 for exactly that cycle.
REQ-020 PLAY, gold_collected: gold_count increments; if the new value equals GOLD_TARGET -> WIN, and gold_count holds (no wrap).
REQ-021 PLAY, player_hit with invuln = 0 and lives > 1: lives decrements; respawn pulses; invuln = 1; invulnerability frame counter loads INV_FRAMES.
REQ-022 PLAY, player_hit with invuln = 0 and lives = 1: lives = 0; -> GAME_OVER; no respawn pulse.
REQ-023 player_hit while invuln = 1 is ignored.
REQ-024 Invulnerability counter decrements on each startOfFrame; invuln clears in the cycle the counter reaches 0.
REQ-025 Simultaneous gold_collected reaching target and player_hit: WIN takes priority; lives unchanged; no respawn.
REQ-026 Simultaneous player_hit and startOfFrame while invuln = 0: hit processed; the counter loads INV_FRAMES and is not decremented that cycle.
REQ-027 Outside PLAY: player_hit and gold_collected are ignored.
REQ-028 WIN or GAME_OVER: key press -> START; lives and gold_count hold until the next new_game.
REQ-029 Encodings 0, 5, 6, 7 are unreachable; if entered, the next cycle forces START.

Reset
REQ-030 On resetN low, asynchronously: game_state = 1, lives = 0, gold_count = 0, new_game = 0, respawn = 0, invuln = 0, counters = 0, previous-key register = 1.
REQ-031 Reset mid-game discards all progress; no new_game pulse until the next key press in START.

Configuration
REQ-032 Macro AUTO_RETURN_EN defined: in WIN and GAME_OVER, a frame counter cleared on state entry counts startOfFrame pulses; after SCREEN_FRAMES pulses -> START. A key press before that still returns to START immediately.
REQ-033 AUTO_RETURN_EN undefined: no frame counter is built; WIN and GAME_OVER exit only on a key press.

Verification
REQ-034 Reset with start_key held high, then held 10 cycles -> game_state stays 1; release and press -> game_state = 2 next cycle, new_game high exactly 1 cycle, lives = 3.
REQ-035 PLAY, lives 3: hit -> lives 2, respawn 1 cycle, invuln 1; second hit 5 cycles later ignored; after 60 startOfFrame pulses invuln = 0.
REQ-036 PLAY, lives 1: hit -> game_state = 4, lives = 0, respawn stays 0; key press -> game_state = 1.
REQ-037 PLAY, gold_count 7: gold_collected and player_hit in the same cycle -> game_state = 3, gold_count = 8, lives unchanged.
REQ-038 AUTO_RETURN_EN with SCREEN_FRAMES = 4, state WIN: 4 startOfFrame pulses -> game_state = 1. Without the macro: 4 pulses -> game_state stays 3.
REQ-039 Assert resetN low mid-PLAY with lives = 2 -> all outputs take the REQ-030 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Game flow controller: START/PLAY/WIN/GAME_OVER sequencing, lives, gold and post-hit invulnerability.
// Define AUTO_RETURN_EN to leave WIN/GAME_OVER automatically after SCREEN_FRAMES frames.
module game_state_ctrl #(
   parameter int LIVES_INIT    = 3,
   parameter int GOLD_TARGET   = 8,
   parameter int INV_FRAMES    = 60,
   parameter int SCREEN_FRAMES = 180
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       start_key,
   input  logic       player_hit,
   input  logic       gold_collected,
   output logic [2:0] game_state,
   output logic [1:0] lives,
   output logic [3:0] gold_count,
   output logic       new_game,
   output logic       respawn,
   output logic       invuln
);

   typedef enum logic [2:0] {
      ST_START = 3'd1,
      ST_PLAY  = 3'd2,
      ST_WIN   = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam bit PARAMS_OK = (LIVES_INIT >= 1) && (LIVES_INIT <= 3) &&
                              (GOLD_TARGET >= 1) && (GOLD_TARGET <= 15) &&
                              (INV_FRAMES >= 1) && (INV_FRAMES <= 255) &&
                              (SCREEN_FRAMES >= 1) && (SCREEN_FRAMES <= 1023);

   if (!PARAMS_OK) begin : g_param_check
      $error("game_state_ctrl: parameter out of range");
   end

   localparam logic [1:0] LIVES_LD  = 2'(LIVES_INIT);
   localparam logic [3:0] GOLD_TGT  = 4'(GOLD_TARGET);
   localparam logic [7:0] INV_LD    = 8'(INV_FRAMES);

   state_t     state_q, state_d;
   logic [1:0] lives_q, lives_d;
   logic [3:0] gold_q, gold_d;
   logic       new_game_q, new_game_d;
   logic       respawn_q, respawn_d;
   logic       invuln_q, invuln_d;
   logic [7:0] inv_cnt_q, inv_cnt_d;
   logic       key_prev_q;

   logic       key_press;
   logic       auto_exit;
   logic [3:0] gold_inc;

   assign key_press = start_key & ~key_prev_q;
   assign gold_inc  = gold_q + 4'd1;

`ifdef AUTO_RETURN_EN
   localparam logic [9:0] SCR_LAST = 10'(SCREEN_FRAMES - 1);

   logic [9:0] scr_cnt_q, scr_cnt_d;
   logic       in_end_screen;

   assign in_end_screen = (state_q == ST_WIN) || (state_q == ST_OVER);
   assign auto_exit     = in_end_screen && startOfFrame && (scr_cnt_q == SCR_LAST);

   // Held at zero outside the end screens, so it is already cleared on entry.
   always_comb begin
      scr_cnt_d = '0;
      if (in_end_screen) begin
         scr_cnt_d = startOfFrame ? scr_cnt_q + 10'd1 : scr_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         scr_cnt_q <= '0;
      end else begin
         scr_cnt_q <= scr_cnt_d;
      end
   end
`else
   assign auto_exit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      gold_d     = gold_q;
      new_game_d = 1'b0;
      respawn_d  = 1'b0;
      invuln_d   = invuln_q;
      inv_cnt_d  = inv_cnt_q;

      // A hit this cycle sees the pre-decrement invuln_q and overrides the counter below.
      if (invuln_q && startOfFrame) begin
         if (inv_cnt_q <= 8'd1) begin
            inv_cnt_d = '0;
            invuln_d  = 1'b0;
         end else begin
            inv_cnt_d = inv_cnt_q - 8'd1;
         end
      end

      case (state_q)
         ST_START: begin
            if (key_press) begin
               state_d    = ST_PLAY;
               lives_d    = LIVES_LD;
               gold_d     = '0;
               invuln_d   = 1'b0;
               inv_cnt_d  = '0;
               new_game_d = 1'b1;
            end
         end
         ST_PLAY: begin
            if (gold_collected) begin
               gold_d = gold_inc;
            end
            if (gold_collected && (gold_inc == GOLD_TGT)) begin
               state_d = ST_WIN;
            end else if (player_hit && !invuln_q) begin
               if (lives_q > 2'd1) begin
                  lives_d   = lives_q - 2'd1;
                  respawn_d = 1'b1;
                  invuln_d  = 1'b1;
                  inv_cnt_d = INV_LD;
               end else begin
                  lives_d = '0;
                  state_d = ST_OVER;
               end
            end
         end
         ST_WIN, ST_OVER: begin
            if (key_press || auto_exit) begin
               state_d = ST_START;
            end
         end
         default: state_d = ST_START;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= ST_START;
         lives_q    <= '0;
         gold_q     <= '0;
         new_game_q <= 1'b0;
         respawn_q  <= 1'b0;
         invuln_q   <= 1'b0;
         inv_cnt_q  <= '0;
         key_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         lives_q    <= lives_d;
         gold_q     <= gold_d;
         new_game_q <= new_game_d;
         respawn_q  <= respawn_d;
         invuln_q   <= invuln_d;
         inv_cnt_q  <= inv_cnt_d;
         key_prev_q <= start_key;
      end
   end

   assign game_state = state_q;
   assign lives      = lives_q;
   assign gold_count = gold_q;
   assign new_game   = new_game_q;
   assign respawn    = respawn_q;
   assign invuln     = invuln_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios with literal expectations, then random play
// checked every cycle against an event-level model of the game rules.
module tb_game_state_ctrl;

   localparam int LIVES = 3;
   localparam int GOLD  = 8;
   localparam int INV   = 60;
   localparam int SCR   = 4;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       startOfFrame = 1'b0;
   logic       start_key = 1'b1;
   logic       player_hit = 1'b0;
   logic       gold_collected = 1'b0;
   logic [2:0] game_state;
   logic [1:0] lives;
   logic [3:0] gold_count;
   logic       new_game;
   logic       respawn;
   logic       invuln;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   game_state_ctrl #(
      .LIVES_INIT(LIVES), .GOLD_TARGET(GOLD), .INV_FRAMES(INV), .SCREEN_FRAMES(SCR)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_key(start_key),
      .player_hit(player_hit), .gold_collected(gold_collected), .game_state(game_state),
      .lives(lives), .gold_count(gold_count), .new_game(new_game), .respawn(respawn),
      .invuln(invuln)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input string name, input int st, input int lv, input int gd,
                             input int ng, input int rs, input int inv);
      chk({name, ".state"}, int'(game_state), st);
      chk({name, ".lives"}, int'(lives), lv);
      chk({name, ".gold"}, int'(gold_count), gd);
      chk({name, ".new_game"}, int'(new_game), ng);
      chk({name, ".respawn"}, int'(respawn), rs);
      chk({name, ".invuln"}, int'(invuln), inv);
   endtask

   task automatic step(input bit s, input bit k, input bit h, input bit g);
      startOfFrame   = s;
      start_key      = k;
      player_hit     = h;
      gold_collected = g;
      @(posedge clk);
      #1;
   endtask

   // Game-rule model: state as a number 1..4, remaining invulnerability as frames left.
   int m_state, m_lives, m_gold, m_left, m_screen;
   bit m_key_prev, m_new_game, m_respawn;

   always @(posedge clk or negedge resetN) begin : model
      int st, lv, gd, left, scr;
      bit ng, rs, press, was_inv, won;
      if (!resetN) begin
         m_state <= 1; m_lives <= 0; m_gold <= 0; m_left <= 0; m_screen <= 0;
         m_key_prev <= 1'b1; m_new_game <= 1'b0; m_respawn <= 1'b0;
      end else begin
         st = m_state; lv = m_lives; gd = m_gold; left = m_left; scr = m_screen;
         ng = 1'b0; rs = 1'b0;
         press   = start_key && !m_key_prev;
         was_inv = (left > 0);
         if (was_inv && startOfFrame) left = left - 1;
         case (st)
            1: if (press) begin st = 2; lv = LIVES; gd = 0; left = 0; ng = 1'b1; end
            2: begin
               won = gold_collected && (gd + 1 == GOLD);
               if (gold_collected) gd = gd + 1;
               if (won) begin
                  st = 3; scr = 0;
               end else if (player_hit && !was_inv) begin
                  if (lv > 1) begin lv = lv - 1; rs = 1'b1; left = INV; end
                  else begin lv = 0; st = 4; scr = 0; end
               end
            end
            default: begin
               if (press) st = 1;
`ifdef AUTO_RETURN_EN
               else if (startOfFrame) begin
                  scr = scr + 1;
                  if (scr == SCR) st = 1;
               end
`endif
            end
         endcase
         m_state <= st; m_lives <= lv; m_gold <= gd; m_left <= left; m_screen <= scr;
         m_key_prev <= start_key; m_new_game <= ng; m_respawn <= rs;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmp.state", int'(game_state), m_state);
         chk("cmp.lives", int'(lives), m_lives);
         chk("cmp.gold", int'(gold_count), m_gold);
         chk("cmp.new_game", int'(new_game), int'(m_new_game));
         chk("cmp.respawn", int'(respawn), int'(m_respawn));
         chk("cmp.invuln", int'(invuln), (m_left > 0) ? 1 : 0);
      end
   end

   initial begin
      bit k;
      // Reset with the key held: holding it afterwards must not start a game.
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      expect_out("reset", 1, 0, 0, 0, 0, 0);
      cmp_en = 1'b1;
      #2 resetN = 1'b1;
      repeat (10) step(0, 1, 0, 0);
      chk("held_key_state", int'(game_state), 1);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      expect_out("press", 2, 3, 0, 1, 0, 0);
      step(0, 0, 0, 0);
      chk("new_game_one_cycle", int'(new_game), 0);

      // First hit, a second hit during invulnerability, then expiry after 60 frames.
      step(0, 0, 1, 0);
      expect_out("hit1", 2, 2, 0, 0, 1, 1);
      step(0, 0, 0, 0);
      chk("respawn_one_cycle", int'(respawn), 0);
      repeat (3) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      expect_out("hit_ignored", 2, 2, 0, 0, 0, 1);
      repeat (59) step(1, 0, 0, 0);
      chk("invuln_after_59", int'(invuln), 1);
      step(1, 0, 0, 0);
      chk("invuln_after_60", int'(invuln), 0);
      chk("pre_reset_lives", int'(lives), 2);

      // Asynchronous reset mid-game, observed before any clock edge.
      #2 resetN = 1'b0;
      #1 expect_out("async_reset", 1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 resetN = 1'b1;

      // Lose all lives.
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      expect_out("new_game2", 2, 3, 0, 1, 0, 0);
      step(0, 0, 1, 0);
      repeat (60) step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      repeat (60) step(1, 0, 0, 0);
      expect_out("last_life", 2, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0);
      expect_out("fatal_hit", 4, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0);
      expect_out("over_to_start", 1, 0, 0, 0, 0, 0);

      // Win wins over a simultaneous hit; then the end-screen timeout behaviour.
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      repeat (7) step(0, 0, 0, 1);
      expect_out("gold7", 2, 3, 7, 0, 0, 0);
      step(0, 0, 1, 1);
      expect_out("win_priority", 3, 3, 8, 0, 0, 0);
      step(0, 0, 1, 1);
      expect_out("win_ignores_events", 3, 3, 8, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0);
      chk("win_after_3_frames", int'(game_state), 3);
      step(1, 0, 0, 0);
`ifdef AUTO_RETURN_EN
      chk("win_after_4_frames", int'(game_state), 1);
`else
      chk("win_after_4_frames", int'(game_state), 3);
`endif

      // Random play against the model.
      k = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 5) == 0) k = ~k;
         if ($urandom_range(0, 799) == 0) begin
            #2 resetN = 1'b0;
            @(posedge clk);
            #1 resetN = 1'b1;
         end
         step(($urandom_range(0, 2) == 0), k, ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 5) == 0));
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
